cmul_fx_pipe: RTL

Parametrised, fully pipelined fixed-point complex multiplier. It is the next-generation successor of the fixed 128-bit complex multiplier. It adds:
- configurable component width and fraction bits,
- a per-sample conjugate mode,
- round-half-up with saturation and an overflow flag/counter,
- a valid/ready handshake on both sides, so downstream FFT/filter blocks can apply backpressure.

It sits between the sample source and any complex datapath consumer, accepting one product per cycle at full throughput.

---
 rtl/cmul_fx_pipe_if.sv | 25 ++
 rtl/cmul_fx_pipe.sv | 117 +++++++++++
 2 files changed

// File: rtl/cmul_fx_pipe_if.sv
// Valid/ready bundle for cmul_fx_pipe: the operand side and the result side.
// The master drives samples and consumer readiness; the slave is the multiplier.
interface cmul_fx_pipe_if #(
  parameter int W = 32
);
  logic           valid;
  logic           ready;
  logic [2*W-1:0] num1;
  logic [2*W-1:0] num2;
  logic           conj;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           ovf;

  modport master (
    output valid, num1, num2, conj, out_ready,
    input  ready, out_valid, result, ovf
  );

  modport slave (
    input  valid, num1, num2, conj, out_ready,
    output ready, out_valid, result, ovf
  );
endinterface

// File: rtl/cmul_fx_pipe.sv
// Four-stage fixed-point complex multiplier with optional conjugate of B,
// round-half-up, saturation, overflow counting and a global-stall handshake.
module cmul_fx_pipe #(
  parameter int W     = 32,
  parameter int FRAC  = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  cmul_fx_pipe_if.slave    bus,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int PW     = 2 * W;
  localparam int SW     = 2 * W + 1;
  localparam int RW     = 2 * W + 2;
  localparam int RND_SH = (FRAC > 0) ? FRAC - 1 : 0;

  localparam logic signed [RW-1:0] RND     = (FRAC > 0) ? (RW'(1) << RND_SH) : '0;
  localparam logic signed [RW-1:0] SAT_MAX = {{(W + 3){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(W + 3){1'b1}}, {(W - 1){1'b0}}};

  function automatic logic signed [PW-1:0] sx(input logic signed [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction

  // Returns {saturated, clamped W-bit value}; the sum is widened by one bit so the
  // rounding constant can never carry into the sign.
  function automatic logic [W:0] round_sat(input logic signed [SW-1:0] v);
    logic signed [RW-1:0] t;
    t = {v[SW-1], v} + RND;
    t = t >>> FRAC;
    if (t > SAT_MAX)      return {1'b1, 1'b0, {(W - 1){1'b1}}};
    else if (t < SAT_MIN) return {1'b1, 1'b1, {(W - 1){1'b0}}};
    else                  return {1'b0, t[W-1:0]};
  endfunction

  logic adv;

  logic                s1_valid;
  logic signed [W-1:0] s1_a, s1_b, s1_c, s1_d;
  logic                s1_conj;

  logic                 s2_valid;
  logic signed [PW-1:0] s2_ac, s2_bd, s2_ad, s2_bc;

  logic                 s3_valid;
  logic signed [SW-1:0] s3_re, s3_im;

  logic signed [PW-1:0] p_ac, p_bd, p_ad, p_bc;
  logic [W:0]           rs_re, rs_im;

  assign adv       = !bus.out_valid || bus.out_ready;
  assign bus.ready = rstn && adv;

  assign p_ac = sx(s1_a) * sx(s1_c);
  assign p_bd = sx(s1_b) * sx(s1_d);
  assign p_ad = sx(s1_a) * sx(s1_d);
  assign p_bc = sx(s1_b) * sx(s1_c);

  assign rs_re = round_sat(s3_re);
  assign rs_im = round_sat(s3_im);

  // Conjugation negates the full-width products, so -(-2^(W-1)) cannot wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid      <= 1'b0;
      s1_a          <= '0;
      s1_b          <= '0;
      s1_c          <= '0;
      s1_d          <= '0;
      s1_conj       <= 1'b0;
      s2_valid      <= 1'b0;
      s2_ac         <= '0;
      s2_bd         <= '0;
      s2_ad         <= '0;
      s2_bc         <= '0;
      s3_valid      <= 1'b0;
      s3_re         <= '0;
      s3_im         <= '0;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.ovf       <= 1'b0;
    end else if (adv) begin
      s1_valid      <= bus.valid;
      s1_a          <= bus.num1[PW-1:W];
      s1_b          <= bus.num1[W-1:0];
      s1_c          <= bus.num2[PW-1:W];
      s1_d          <= bus.num2[W-1:0];
      s1_conj       <= bus.conj;
      s2_valid      <= s1_valid;
      s2_ac         <= p_ac;
      s2_bc         <= p_bc;
      s2_bd         <= s1_conj ? -p_bd : p_bd;
      s2_ad         <= s1_conj ? -p_ad : p_ad;
      s3_valid      <= s2_valid;
      s3_re         <= {s2_ac[PW-1], s2_ac} - {s2_bd[PW-1], s2_bd};
      s3_im         <= {s2_ad[PW-1], s2_ad} + {s2_bc[PW-1], s2_bc};
      bus.out_valid <= s3_valid;
      bus.result    <= {rs_re[W-1:0], rs_im[W-1:0]};
      bus.ovf       <= s3_valid && (rs_re[W] || rs_im[W]);
    end
  end

  // Clear has priority over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_cnt <= '0;
    end else if (clr_cnt) begin
      ovf_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready && bus.ovf && !(&ovf_cnt)) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule
